// File: rtl/uart_msg_parser.sv
// uart_msg_parser: parses "S:ddd.dd\n" / "P:ddd.dd\n" lines into fixed-point cents
module uart_msg_parser #(
  parameter int VAL_W          = 17,
  parameter int MAX_INT_DIGITS = 3,
  parameter int THRESH_RESET   = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [VAL_W-1:0] price,
  output logic             price_valid,
  output logic [VAL_W-1:0] threshold,
  output logic             thresh_valid,
  output logic             parse_err
);
  localparam int CW = $clog2(MAX_INT_DIGITS + 1);
  typedef enum logic [2:0] {IDLE, COLON, INT_D, FRAC1, FRAC2, EOL, ERR} state_t;
  state_t         state;
  logic           cmd_p;
  logic [VAL_W-1:0] acc, acc_dig;
  logic [CW-1:0]  cnt;
  logic           is_dig, is_lf, is_cr, is_cmd, ok;
  // classify the incoming byte and decide whether it is legal in the current state
  always_comb begin
    is_dig  = rx_data >= 8'h30 && rx_data <= 8'h39;
    is_lf   = rx_data == 8'h0A;
    is_cr   = rx_data == 8'h0D;
    is_cmd  = rx_data == 8'h53 || rx_data == 8'h50;
    acc_dig = acc * VAL_W'(10) + {{(VAL_W-4){1'b0}}, rx_data[3:0]};
    ok = state == IDLE  ? is_cmd || is_lf :
         state == COLON ? rx_data == 8'h3A :
         state == INT_D ? (is_dig && cnt < CW'(MAX_INT_DIGITS)) || (rx_data == 8'h2E && cnt != '0) :
         state == FRAC1 || state == FRAC2 ? is_dig :
         state == EOL   ? is_lf : 1'b1;
  end
  // line FSM with registered value outputs and single-cycle pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cmd_p        <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      price        <= '0;
      threshold    <= VAL_W'(THRESH_RESET);
      price_valid  <= 1'b0;
      thresh_valid <= 1'b0;
      parse_err    <= 1'b0;
    end else begin
      price_valid  <= 1'b0;
      thresh_valid <= 1'b0;
      parse_err    <= 1'b0;
      if (rx_valid && !is_cr) begin
        if (!ok) begin
          parse_err <= 1'b1;
          state     <= is_lf ? IDLE : ERR;
        end else begin
          case (state)
            IDLE: if (is_cmd) begin
              cmd_p <= rx_data == 8'h50;
              state <= COLON;
            end
            COLON: begin
              acc   <= '0;
              cnt   <= '0;
              state <= INT_D;
            end
            INT_D: if (is_dig) begin
              acc <= acc_dig;
              cnt <= cnt + CW'(1);
            end else state <= FRAC1;
            FRAC1: begin
              acc   <= acc_dig;
              state <= FRAC2;
            end
            FRAC2: begin
              acc   <= acc_dig;
              state <= EOL;
            end
            EOL: begin
              state <= IDLE;
              if (cmd_p) begin
                price       <= acc;
                price_valid <= 1'b1;
              end else begin
                threshold    <= acc;
                thresh_valid <= 1'b1;
              end
            end
            default: if (is_lf) state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_msg_parser.sv
// tb_uart_msg_parser: scoreboard bench for the line parser
module tb_uart_msg_parser;
  localparam int VAL_W = 17;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic [VAL_W-1:0] price, threshold;
  logic price_valid, thresh_valid, parse_err;
  uart_msg_parser #(.VAL_W(VAL_W), .MAX_INT_DIGITS(3), .THRESH_RESET(20000)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .price(price), .price_valid(price_valid),
    .threshold(threshold), .thresh_valid(thresh_valid), .parse_err(parse_err)
  );
  always #10 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0, bad = 0;
  typedef struct {int kind; int val; longint cyc;} ev_t;
  ev_t q[$];
  ev_t e;
  logic [2:0] p, prev = 3'b000;
  int ko;
  // kind: 1 = price commit, 2 = threshold commit, 3 = parse error
  always @(negedge clk) begin
    if (!rst) prev = 3'b000;
    else begin
      p = {parse_err, thresh_valid, price_valid};
      if (p != 3'b000) begin
        total++;
        if ($countones(p) > 1) begin
          bad++;
          $display("FAIL onehot cyc=%0d pulses=%b required at most one", cyc, p);
        end
        total++;
        if ((p & prev) != 3'b000) begin
          bad++;
          $display("FAIL pulse_width cyc=%0d pulses=%b prev=%b required single cycle", cyc, p, prev);
        end
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse cyc=%0d pulses=%b required none", cyc, p);
        end else begin
          e = q.pop_front();
          ko = p[0] ? 1 : p[1] ? 2 : 3;
          if (ko !== e.kind || cyc !== e.cyc) begin
            bad++;
            $display("FAIL event kind=%0d cyc=%0d required kind=%0d cyc=%0d", ko, cyc, e.kind, e.cyc);
          end else if (ko == 1 && price !== VAL_W'(e.val)) begin
            bad++;
            $display("FAIL price_value got=%0d required=%0d", price, e.val);
          end else if (ko == 2 && threshold !== VAL_W'(e.val)) begin
            bad++;
            $display("FAIL thresh_value got=%0d required=%0d", threshold, e.val);
          end
        end
      end
      prev = p;
    end
  end
  task automatic send_line(input string s, input int gap, input int err_idx, input int kind, input int val);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_data  = s[i];
      rx_valid = 1'b1;
      if (i == err_idx) q.push_back('{3, 0, cyc + 1});
      if (i == s.len() - 1 && kind != 0) q.push_back('{kind, val, cyc + 1});
      if (gap > 1) begin
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap - 2) @(negedge clk);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s pending=%0d required=0", name, q.size());
      q.delete();
    end
  endtask
  task automatic check_vals(input string name, input int pv, input int tv);
    total++;
    if (price !== VAL_W'(pv)) begin
      bad++;
      $display("FAIL %s_price got=%0d required=%0d", name, price, pv);
    end
    total++;
    if (threshold !== VAL_W'(tv)) begin
      bad++;
      $display("FAIL %s_thresh got=%0d required=%0d", name, threshold, tv);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_vals("reset", 0, 20000);
    total++;
    if ({price_valid, thresh_valid, parse_err} !== 3'b000) begin
      bad++;
      $display("FAIL reset_pulses got=%b required=000", {price_valid, thresh_valid, parse_err});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_basic();
    send_line("S:200.00\n", 4, -1, 2, 20000);
    drain("basic_s");
    check_vals("basic_s", 0, 20000);
    send_line("P:123.45\n", 4, -1, 1, 12345);
    drain("basic_p");
    check_vals("basic_p", 12345, 20000);
  endtask
  task automatic test_back_to_back();
    send_line("P:999.99\r\n", 1, -1, 1, 99999);
    drain("b2b_max");
    check_vals("b2b_max", 99999, 20000);
    send_line("P:0.07\n", 4, -1, 1, 7);
    drain("small");
    check_vals("small", 7, 20000);
  endtask
  task automatic test_overflow();
    send_line("P:1234.00\n", 4, 5, 0, 0);
    drain("overflow");
    check_vals("overflow", 7, 20000);
    send_line("P:1.00\n", 4, -1, 1, 100);
    drain("after_overflow");
    check_vals("after_overflow", 100, 20000);
  endtask
  task automatic test_errors();
    send_line("P:5.5\n", 4, 5, 0, 0);
    send_line("S:3.21\n", 4, -1, 2, 321);
    send_line("x\n", 4, 0, 0, 0);
    send_line("\n", 4, -1, 0, 0);
    send_line("S200.00\n", 4, 1, 0, 0);
    send_line("P:.50\n", 4, 2, 0, 0);
    send_line("p:1.00\n", 4, 0, 0, 0);
    send_line("S:12.\n", 1, 5, 0, 0);
    drain("errors");
    check_vals("errors", 100, 321);
  endtask
  task automatic test_reset_midline();
    send_line("S:1", 4, -1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_vals("in_reset", 0, 20000);
    rst = 1'b1;
    send_line("23.00\n", 4, 0, 0, 0);
    drain("midline");
    check_vals("midline", 0, 20000);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_errors();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
